bitplane_popcount_feeder: RTL and testbench

Upstream stage of the accumulating shift-add block. It latches one vector of N multi-bit activations and a stored N-bit binary weight row. It then emits, MSB plane first, one popcount of (weight AND activation-bit) per cycle as a partial sum. Frames are timed so that IB valid planes are followed by one idle cycle, which matches the 5-cycle cadence of the downstream accumulator when IB=4.

---
 rtl/bitplane_popcount_feeder.sv | 91 +++++++++
 tb/tb_bitplane_popcount_feeder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bitplane_popcount_feeder.sv
// bitplane_popcount_feeder: latches N IB-bit activations and emits, MSB plane first, popcount(w_reg & plane bits) per cycle.
// Ports: clk/rst (async, active-high); w_load/w_data load the weight row in IDLE; in_valid/in_ready/in_data accept one
// activation vector; partial_sum/ps_valid/ps_plane/ps_last stream one plane per cycle; skip_cnt counts all-zero planes.
// Optional macro ZERO_SKIP_EN: counts all-zero planes, holds partial_sum on them and flags them on ps_zero.
module bitplane_popcount_feeder #(
  parameter int N   = 16,
  parameter int IB  = 4,
  parameter int PSW = 5,
  parameter int PW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            w_load,
  input  logic [N-1:0]    w_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*IB-1:0] in_data,
  output logic [PSW-1:0]  partial_sum,
  output logic            ps_valid,
  output logic [PW-1:0]   ps_plane,
  output logic            ps_last,
`ifdef ZERO_SKIP_EN
  output logic            ps_zero,
`endif
  output logic [15:0]     skip_cnt
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_n;
  logic [N-1:0] w_reg, and_v;
  logic [N*IB-1:0] data_reg;
  logic [PW-1:0] plane;
  logic [PSW-1:0] pc;
  logic [IB-1:0] lane;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb state_n = state == IDLE ? (in_valid ? EMIT : IDLE) : (plane == '0 ? IDLE : EMIT);
  always_comb in_ready = state == IDLE;
  always_comb begin
    and_v = '0;
    pc = '0;
    lane = '0;
    for (int i = 0; i < N; i++) begin
      lane = data_reg[i*IB +: IB];
      and_v[i] = w_reg[i] & lane[plane];
      pc = pc + PSW'(and_v[i]);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_reg <= '0;
      data_reg <= '0;
      plane <= '0;
      partial_sum <= '0;
      ps_valid <= 1'b0;
      ps_plane <= '0;
      ps_last <= 1'b0;
`ifdef ZERO_SKIP_EN
      ps_zero <= 1'b0;
`endif
    end else if (state == IDLE) begin
      ps_valid <= 1'b0;
      ps_last <= 1'b0;
`ifdef ZERO_SKIP_EN
      ps_zero <= 1'b0;
`endif
      if (w_load) w_reg <= w_data;
      if (in_valid) begin
        data_reg <= in_data;
        plane <= PW'(IB - 1);
      end
    end else begin
      ps_valid <= 1'b1;
      ps_plane <= plane;
      ps_last <= plane == '0;
`ifdef ZERO_SKIP_EN
      ps_zero <= and_v == '0;
      if (and_v != '0) partial_sum <= pc;
`else
      partial_sum <= pc;
`endif
      if (plane != '0) plane <= plane - 1'b1;
    end
`ifdef ZERO_SKIP_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) skip_cnt <= '0;
    else if (state == EMIT && and_v == '0 && skip_cnt != 16'hFFFF) skip_cnt <= skip_cnt + 1'b1;
`else
  assign skip_cnt = '0;
`endif
endmodule

// File: tb/tb_bitplane_popcount_feeder.sv
// tb_bitplane_popcount_feeder: randomized and directed check of the bit-plane popcount feeder against a frame-level model.
module tb_bitplane_popcount_feeder;
  localparam int N = 16, IB = 4, PSW = 5, PW = 2;
  logic clk = 0, rst = 1, w_load = 0, in_valid = 0;
  logic [N-1:0] w_data = '0;
  logic [N*IB-1:0] in_data = '0;
  logic in_ready, ps_valid, ps_last;
  logic [PSW-1:0] partial_sum;
  logic [PW-1:0] ps_plane;
  logic [15:0] skip_cnt;
`ifdef ZERO_SKIP_EN
  logic ps_zero;
`endif
  int compared = 0, mismatched = 0;
  typedef struct {logic [PSW-1:0] ps; logic [PW-1:0] pl; logic last; logic z;} ent_t;
  ent_t q[$];
  ent_t obs[$];
  ent_t cur;
  logic cur_v = 0, rdy;
  logic [PSW-1:0] last_ps = '0;
  logic [N-1:0] wm = '0;
  int skip_m = 0;
  bitplane_popcount_feeder #(.N(N), .IB(IB), .PSW(PSW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .w_load(w_load), .w_data(w_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .partial_sum(partial_sum), .ps_valid(ps_valid), .ps_plane(ps_plane), .ps_last(ps_last),
`ifdef ZERO_SKIP_EN
    .ps_zero(ps_zero),
`endif
    .skip_cnt(skip_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Frame-level model: an accepted vector becomes IB queued plane results; the block is free when the queue is empty.
  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      cur_v = 0;
      last_ps = '0;
      wm = '0;
      skip_m = 0;
    end else begin
      rdy = q.size() == 0;
      cur_v = !rdy;
      if (!rdy) begin
        cur = q.pop_front();
        if (cur.z && skip_m < 65535) skip_m++;
      end
      if (rdy && w_load) wm = w_data;
      if (rdy && in_valid)
        for (int p = IB - 1; p >= 0; p--) begin
          int c;
          ent_t e;
          c = 0;
          for (int i = 0; i < N; i++) if (wm[i[3:0]] && in_data[6'(i*IB + p)]) c++;
          e.z = c == 0;
`ifdef ZERO_SKIP_EN
          if (!e.z) last_ps = PSW'(c);
          e.ps = last_ps;
`else
          e.ps = PSW'(c);
`endif
          e.pl = PW'(p);
          e.last = p == 0;
          q.push_back(e);
        end
    end
  always @(negedge clk)
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
      chk("ps_valid", 32'(ps_valid), 32'(cur_v));
      if (cur_v) begin
        chk("partial_sum", 32'(partial_sum), 32'(cur.ps));
        chk("ps_plane", 32'(ps_plane), 32'(cur.pl));
        chk("ps_last", 32'(ps_last), 32'(cur.last));
`ifdef ZERO_SKIP_EN
        chk("ps_zero", 32'(ps_zero), 32'(cur.z));
`endif
        obs.push_back('{partial_sum, ps_plane, ps_last, 1'b0});
      end else chk("ps_last_idle", 32'(ps_last), 0);
`ifdef ZERO_SKIP_EN
      chk("skip_cnt", 32'(skip_cnt), 32'(skip_m));
`endif
    end
  function automatic logic [N*IB-1:0] rep(input logic [IB-1:0] v);
    return {N{v}};
  endfunction
  task automatic frame(input logic wl, input logic [N-1:0] wd, input logic [N*IB-1:0] d);
    w_load = wl;
    w_data = wd;
    in_valid = 1;
    in_data = d;
    @(negedge clk);
    w_load = 0;
    in_valid = 0;
    in_data = {$urandom, $urandom};
    repeat (IB + 1) @(negedge clk);
  endtask
  task automatic chk_obs(input string name, input int e3, input int e2, input int e1, input int e0);
    int exp[4];
    exp = '{e3, e2, e1, e0};
    chk({name, "_count"}, obs.size(), 4);
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      chk(name, 32'(obs[i].ps), exp[i]);
      chk({name, "_plane"}, 32'(obs[i].pl), 3 - i);
      chk({name, "_last"}, 32'(obs[i].last), 32'(i == 3));
    end
  endtask
  initial begin
    int op;
    #1;
    chk("rst_partial_sum", 32'(partial_sum), 0);
    chk("rst_ps_valid", 32'(ps_valid), 0);
    chk("rst_ps_last", 32'(ps_last), 0);
    chk("rst_ps_plane", 32'(ps_plane), 0);
    chk("rst_skip_cnt", 32'(skip_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    obs.delete();
    frame(1, 16'hFFFF, rep(4'hF));
    chk_obs("basic", 16, 16, 16, 16);
    op = 0;
    foreach (obs[i]) op += int'(obs[i].ps) << obs[i].pl;
    chk("basic_op", op, 240);
    obs.delete();
    frame(0, 16'h0, {8{8'h5A}});
    chk_obs("mixed", 8, 8, 8, 8);
    obs.delete();
    frame(1, 16'h00FF, rep(4'h9));
`ifdef ZERO_SKIP_EN
    chk_obs("mask", 8, 8, 8, 8);
`else
    chk_obs("mask", 8, 0, 0, 8);
`endif
    obs.delete();
    w_load = 1;
    w_data = 16'hFFFF;
    in_valid = 1;
    in_data = rep(4'hF);
    @(negedge clk);
    w_data = 16'h0;
    @(negedge clk);
    w_load = 0;
    repeat (13) @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    chk("b2b_count", obs.size(), 12);
    foreach (obs[i]) chk("b2b_ps", 32'(obs[i].ps), 16);
    frame(0, 16'h0, rep(4'hF));
    w_data = 16'h0;
    in_valid = 1;
    in_data = rep(4'hF);
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    chk("midrst_ps_valid", 32'(ps_valid), 0);
    chk("midrst_partial_sum", 32'(partial_sum), 0);
    chk("midrst_ps_last", 32'(ps_last), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
`ifdef ZERO_SKIP_EN
    frame(0, 16'h0, '0);
    frame(0, 16'h0, '0);
    chk("zs_skip_cnt", 32'(skip_cnt), 8);
`endif
    obs.delete();
    frame(0, 16'h0, rep(4'hF));
    chk_obs("after_rst", 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      w_load = $urandom_range(0, 3) == 0;
      w_data = N'($urandom);
      in_valid = $urandom_range(0, 2) != 0;
      in_data = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) in_data = rep(4'h0);
      @(negedge clk);
    end
    in_valid = 0;
    w_load = 0;
    repeat (IB + 2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
